hazard_ctrl: RTL and testbench

- Parametrised, unified hazard controller for the 5-stage MIPS pipeline.
- Replaces the separate data-hazard and branch-hazard detectors with one block. It drives the stall, bubble and flush controls and the EX/ID forwarding selects.
- Unlike its predecessors it is configurable in register-index width, load-use latency and mult/div latency.
- It holds state: it counts multi-cycle stall windows and tracks the busy mult/div unit, so a hazard longer than one bubble is covered without re-detection.

---
 rtl/hazard_ctrl_pkg.sv | 44 ++++
 rtl/hazard_md_tracker.sv | 29 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller and the ID-stage decoder:
// forward selects, stall FSM states and the opcodes that classify branch/md ops.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LW     = 6'h23;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  function automatic logic op_is_branch(input logic [5:0] op);
    return op inside {OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
  endfunction

  function automatic logic op_is_md(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) &&
           (funct inside {FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return op == OP_LW;
  endfunction

endpackage

// File: rtl/hazard_md_tracker.sv
// Mult/div busy window: md_start (re)loads MD_LAT, counts down to idle.
module hazard_md_tracker #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MD_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= LAT;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - ONE;
    end
  end

  assign md_busy = md_cnt != '0;

endmodule

// File: rtl/hazard_ctrl.sv
// Unified hazard controller: stall/bubble/flush, EX and ID-branch forwarding,
// multi-cycle stall windows and mult/div busy tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MD_LAT       = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_md,
  input  logic             br_taken,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             md_start,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             br_fwd_a,
  output logic             br_fwd_b,
  output logic             md_busy
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LB_N   = CNT_W'(LOAD_BUBBLES);
  localparam logic [CNT_W-1:0] LB_N_1 = CNT_W'(LOAD_BUBBLES + 1);

  hz_state_t        state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] need_n;
  logic             md_busy_int;
  logic             ex_match;
  logic             mem_match;
  logic             stall;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;

  hazard_md_tracker #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_tracker (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_busy  (md_busy_int)
  );

  assign ex_match  = (ex_dst != '0) &&
                     ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_match = (mem_dst != '0) &&
                     ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));

  // Worst case over all hazards seen this cycle; HOLD counts this value down.
  always_comb begin
    need_n = '0;
    if (ex_mem_read && ex_match && (need_n < LB_N))
      need_n = LB_N;
    if (id_is_branch && ex_reg_write && !ex_mem_read && ex_match && (need_n < ONE))
      need_n = ONE;
    if (id_is_branch && ex_mem_read && ex_match && (need_n < LB_N_1))
      need_n = LB_N_1;
    if (id_is_branch && mem_mem_read && mem_match && (need_n < LB_N))
      need_n = LB_N;
    if (id_is_md && md_busy_int && (need_n < ONE))
      need_n = ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HZ_RUN;
      stall_cnt <= '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (need_n > ONE) begin
            stall_cnt <= need_n - ONE;
            state     <= HZ_HOLD;
          end
        end
        HZ_HOLD: begin
          if (stall_cnt <= ONE) begin
            stall_cnt <= '0;
            state     <= HZ_RUN;
          end else begin
            stall_cnt <= stall_cnt - ONE;
          end
        end
        default: begin
          stall_cnt <= '0;
          state     <= HZ_RUN;
        end
      endcase
    end
  end

  assign stall = !rst && (((state == HZ_RUN) && (need_n != '0)) || (state == HZ_HOLD));

  assign pc_hold      = stall;
  assign if_id_hold   = stall;
  assign id_ex_bubble = stall;
  assign if_id_flush  = !rst && br_taken && id_is_branch && !stall;

  always_comb begin
    fwd_a_sel = FWD_RF;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rs))
      fwd_a_sel = FWD_EXMEM;
    else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs))
      fwd_a_sel = FWD_MEMWB;

    fwd_b_sel = FWD_RF;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rt))
      fwd_b_sel = FWD_EXMEM;
    else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt))
      fwd_b_sel = FWD_MEMWB;
  end

  assign fwd_a = rst ? FWD_RF : fwd_a_sel;
  assign fwd_b = rst ? FWD_RF : fwd_b_sel;

  assign br_fwd_a = !rst && id_is_branch && mem_reg_write && !mem_mem_read &&
                    (mem_dst != '0) && (mem_dst == id_rs);
  assign br_fwd_b = !rst && id_is_branch && mem_reg_write && !mem_mem_read &&
                    (mem_dst != '0) && (mem_dst == id_rt);

  assign md_busy = !rst && md_busy_int;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LOAD_BUBBLES=1 and =2 instances side by side;
// expectations are queued per cycle and checked by a negedge monitor.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_dst, ex_rs, ex_rt, mem_dst, wb_dst;
  logic       id_uses_rt, id_is_branch, id_is_md, br_taken;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write, md_start;

  logic       pc_hold1, if_id_hold1, id_ex_bubble1, if_id_flush1, br_fwd_a1, br_fwd_b1, md_busy1;
  logic [1:0] fwd_a1, fwd_b1;
  logic       pc_hold2, if_id_hold2, id_ex_bubble2, if_id_flush2, br_fwd_a2, br_fwd_b2, md_busy2;
  logic [1:0] fwd_a2, fwd_b2;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .LOAD_BUBBLES(1), .MD_LAT(4), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_md(id_is_md), .br_taken(br_taken),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .wb_reg_write(wb_reg_write),
    .wb_dst(wb_dst), .md_start(md_start),
    .pc_hold(pc_hold1), .if_id_hold(if_id_hold1), .id_ex_bubble(id_ex_bubble1),
    .if_id_flush(if_id_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .br_fwd_a(br_fwd_a1), .br_fwd_b(br_fwd_b1), .md_busy(md_busy1)
  );

  hazard_ctrl #(.REG_W(5), .LOAD_BUBBLES(2), .MD_LAT(4), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_md(id_is_md), .br_taken(br_taken),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .wb_reg_write(wb_reg_write),
    .wb_dst(wb_dst), .md_start(md_start),
    .pc_hold(pc_hold2), .if_id_hold(if_id_hold2), .id_ex_bubble(id_ex_bubble2),
    .if_id_flush(if_id_flush2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .br_fwd_a(br_fwd_a2), .br_fwd_b(br_fwd_b2), .md_busy(md_busy2)
  );

  logic [10:0] o1, o2;
  assign o1 = {pc_hold1, if_id_hold1, id_ex_bubble1, if_id_flush1, fwd_a1, fwd_b1,
               br_fwd_a1, br_fwd_b1, md_busy1};
  assign o2 = {pc_hold2, if_id_hold2, id_ex_bubble2, if_id_flush2, fwd_a2, fwd_b2,
               br_fwd_a2, br_fwd_b2, md_busy2};

  typedef struct {
    string       name;
    logic [10:0] e1;
    logic [10:0] e2;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // {hold x3, flush, fwd_a, fwd_b, br_fwd_a, br_fwd_b, md_busy}
  function automatic logic [10:0] ev(input logic h, input logic f, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic ba, input logic bb,
                                     input logic mb);
    return {h, h, h, f, fa, fb, ba, bb, mb};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (o1 !== e.e1) begin
        failures++;
        $display("FAIL %s lb1 got=%b want=%b", e.name, o1, e.e1);
      end
      checks++;
      if (o2 !== e.e2) begin
        failures++;
        $display("FAIL %s lb2 got=%b want=%b", e.name, o2, e.e2);
      end
    end
  end

  task automatic idle();
    rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
    id_is_md = 1'b0; br_taken = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_dst = '0; ex_rs = '0; ex_rt = '0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    mem_dst = '0; wb_reg_write = 1'b0; wb_dst = '0; md_start = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [10:0] e1, input logic [10:0] e2);
    sb.push_back('{nm, e1, e2});
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic lw_ex(input logic [4:0] d);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = d;
  endtask

  task automatic branch_id(input logic [4:0] rs, input logic [4:0] rt, input logic tk);
    id_is_branch = 1'b1; id_rs = rs; id_rt = rt; id_uses_rt = 1'b1; br_taken = tk;
  endtask

  logic [10:0] z, h;

  initial begin
    z = ev(0, 0, 2'b00, 2'b00, 0, 0, 0);
    h = ev(1, 0, 2'b00, 2'b00, 0, 0, 0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    rst = 1'b1; lw_ex(5'd2); id_rs = 5'd2; md_start = 1'b1;
    cyc("reset_outputs", z, z);

    lw_ex(5'd2); id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    cyc("loaduse_detect", h, h);
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    cyc("loaduse_second", z, h);
    wb_reg_write = 1'b1; wb_dst = 5'd2; ex_reg_write = 1'b1; ex_dst = 5'd3;
    ex_rs = 5'd2; ex_rt = 5'd4;
    cyc("loaduse_fwd_wb", ev(0, 0, 2'b01, 2'b00, 0, 0, 0), ev(0, 0, 2'b01, 2'b00, 0, 0, 0));

    lw_ex(5'd5); branch_id(5'd5, 5'd0, 1'b1);
    cyc("brload_c1", h, h);
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd5; branch_id(5'd5, 5'd0, 1'b1);
    cyc("brload_c2", h, h);
    wb_reg_write = 1'b1; wb_dst = 5'd5; branch_id(5'd5, 5'd0, 1'b1);
    cyc("brload_c3", ev(0, 1, 2'b00, 2'b00, 0, 0, 0), h);
    branch_id(5'd5, 5'd0, 1'b1);
    cyc("brload_c4_flush", ev(0, 1, 2'b00, 2'b00, 0, 0, 0), ev(0, 1, 2'b00, 2'b00, 0, 0, 0));

    ex_reg_write = 1'b1; ex_dst = 5'd7; branch_id(5'd7, 5'd8, 1'b1);
    cyc("bralu_stall", h, h);
    mem_reg_write = 1'b1; mem_dst = 5'd7; branch_id(5'd7, 5'd8, 1'b1);
    cyc("bralu_brfwd", ev(0, 1, 2'b00, 2'b00, 1, 0, 0), ev(0, 1, 2'b00, 2'b00, 1, 0, 0));

    md_start = 1'b1;
    cyc("md_start", z, z);
    cyc("md_busy_idle", ev(0, 0, 2'b00, 2'b00, 0, 0, 1), ev(0, 0, 2'b00, 2'b00, 0, 0, 1));
    for (int i = 0; i < 3; i++) begin
      id_is_md = 1'b1;
      cyc("md_conflict", ev(1, 0, 2'b00, 2'b00, 0, 0, 1), ev(1, 0, 2'b00, 2'b00, 0, 0, 1));
    end
    id_is_md = 1'b1;
    cyc("md_release", z, z);

    md_start = 1'b1;
    cyc("md_start2", z, z);
    md_start = 1'b1;
    cyc("md_reload", ev(0, 0, 2'b00, 2'b00, 0, 0, 1), ev(0, 0, 2'b00, 2'b00, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      cyc("md_reload_busy", ev(0, 0, 2'b00, 2'b00, 0, 0, 1), ev(0, 0, 2'b00, 2'b00, 0, 0, 1));
    cyc("md_reload_done", z, z);

    mem_reg_write = 1'b1; mem_dst = 5'd9; wb_reg_write = 1'b1; wb_dst = 5'd9;
    ex_rs = 5'd9; ex_rt = 5'd9;
    cyc("fwd_priority", ev(0, 0, 2'b10, 2'b10, 0, 0, 0), ev(0, 0, 2'b10, 2'b10, 0, 0, 0));
    wb_reg_write = 1'b1; wb_dst = 5'd9; ex_rs = 5'd1; ex_rt = 5'd9;
    cyc("fwd_wb_only", ev(0, 0, 2'b00, 2'b01, 0, 0, 0), ev(0, 0, 2'b00, 2'b01, 0, 0, 0));
    mem_reg_write = 1'b1; wb_reg_write = 1'b1; lw_ex(5'd0); branch_id(5'd0, 5'd0, 1'b0);
    cyc("reg0_no_hazard", z, z);

    lw_ex(5'd5); branch_id(5'd5, 5'd0, 1'b1); md_start = 1'b1;
    cyc("rsthold_enter", h, h);
    rst = 1'b1; mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd5;
    branch_id(5'd5, 5'd0, 1'b1); id_is_md = 1'b1;
    cyc("rsthold_forced0", z, z);
    branch_id(5'd5, 5'd0, 1'b1);
    cyc("rsthold_released", ev(0, 1, 2'b00, 2'b00, 0, 0, 0), ev(0, 1, 2'b00, 2'b00, 0, 0, 0));
    cyc("final_idle", z, z);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
